// File: rtl/rename_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : rename_regfile_mp
// Description : Multi-ported architectural register file with per-register
//               rename tags and explicit busy bits. Up to DISP_W dispatch slots
//               rename destinations and read two sources each per cycle. Up to
//               COMMIT_W ROB commit ports write results back per cycle.
//               Busy bits are explicit, so every ROB tag value is usable.
// Ports       : clk, rst          clock, synchronous active-high reset
//               rdy               global enable; low freezes all state
//               flush             clears every busy bit; dispatch ignored
//               cm_valid/rd/tag/data  commit ports, port c at slice c
//               ds_valid/rd/tag   dispatch slots (slot 0 oldest)
//               ds_rs1/ds_rs2     per-slot source register indices
//               rs1_*/rs2_*       per-slot source readiness, tag and value
//                                 (combinational, no added latency)
// Revision    : 1.0 - initial release
// ============================================================================
module rename_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int DISP_W   = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic [COMMIT_W-1:0]        cm_valid,
    input  logic [5*COMMIT_W-1:0]      cm_rd,
    input  logic [TAG_W*COMMIT_W-1:0]  cm_tag,
    input  logic [XLEN*COMMIT_W-1:0]   cm_data,
    input  logic [DISP_W-1:0]          ds_valid,
    input  logic [5*DISP_W-1:0]        ds_rd,
    input  logic [TAG_W*DISP_W-1:0]    ds_tag,
    input  logic [5*DISP_W-1:0]        ds_rs1,
    input  logic [5*DISP_W-1:0]        ds_rs2,
    output logic [DISP_W-1:0]          rs1_rdy,
    output logic [TAG_W*DISP_W-1:0]    rs1_tag,
    output logic [XLEN*DISP_W-1:0]     rs1_val,
    output logic [DISP_W-1:0]          rs2_rdy,
    output logic [TAG_W*DISP_W-1:0]    rs2_tag,
    output logic [XLEN*DISP_W-1:0]     rs2_val
);

    // x0 has no storage: arrays span registers 1..31 only.
    logic [31:1][XLEN-1:0]  r_val;
    logic [31:1]            r_busy;
    logic [31:1][TAG_W-1:0] r_tag;

    // ------------------------------------------------------------------------
    // Read path. Priority per source: x0, intra-bundle rename from an older
    // slot, commit bypass of the awaited tag, pending producer, stored value.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [4:0]       w_src;
        logic             w_rdy;
        logic [TAG_W-1:0] w_tag;
        logic [XLEN-1:0]  w_val;
        logic             w_hit;
        logic             w_byp;

        w_src   = '0;
        w_rdy   = 1'b1;
        w_tag   = '0;
        w_val   = '0;
        w_hit   = 1'b0;
        w_byp   = 1'b0;
        rs1_rdy = '0;
        rs1_tag = '0;
        rs1_val = '0;
        rs2_rdy = '0;
        rs2_tag = '0;
        rs2_val = '0;

        for (int j = 0; j < DISP_W; j++) begin
            for (int k = 0; k < 2; k++) begin
                w_src = (k == 0) ? ds_rs1[5*j +: 5] : ds_rs2[5*j +: 5];
                w_rdy = 1'b1;
                w_tag = '0;
                w_val = '0;
                w_hit = 1'b0;
                w_byp = 1'b0;

                if (w_src != 5'd0) begin
                    // Scanning oldest to youngest lets the youngest older
                    // renamer overwrite earlier matches.
                    for (int i = 0; i < DISP_W; i++) begin
                        if (i < j && ds_valid[i] && ds_rd[5*i +: 5] == w_src) begin
                            w_hit = 1'b1;
                            w_tag = ds_tag[TAG_W*i +: TAG_W];
                        end
                    end

                    if (w_hit) begin
                        w_rdy = 1'b0;
                    end else if (r_busy[w_src]) begin
                        // Highest matching commit port wins the bypass.
                        for (int c = 0; c < COMMIT_W; c++) begin
                            if (cm_valid[c] && cm_rd[5*c +: 5] == w_src &&
                                cm_tag[TAG_W*c +: TAG_W] == r_tag[w_src]) begin
                                w_byp = 1'b1;
                                w_val = cm_data[XLEN*c +: XLEN];
                            end
                        end
                        if (w_byp) begin
                            w_rdy = 1'b1;
                        end else begin
                            w_rdy = 1'b0;
                            w_tag = r_tag[w_src];
                        end
                    end else begin
                        w_val = r_val[w_src];
                    end
                end

                if (k == 0) begin
                    rs1_rdy[j]                  = w_rdy;
                    rs1_tag[TAG_W*j +: TAG_W]   = w_tag;
                    rs1_val[XLEN*j +: XLEN]     = w_val;
                end else begin
                    rs2_rdy[j]                  = w_rdy;
                    rs2_tag[TAG_W*j +: TAG_W]   = w_tag;
                    rs2_val[XLEN*j +: XLEN]     = w_val;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // State update. Later non-blocking assignments override earlier ones, so
    // loop order gives: highest commit port wins, dispatch overrides a busy
    // clear of the same register, highest dispatch slot wins. Busy clears
    // compare against the pre-update tag.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val  <= '0;
            r_busy <= '0;
            r_tag  <= '0;
        end else if (rdy) begin
            for (int c = 0; c < COMMIT_W; c++) begin
                if (cm_valid[c] && cm_rd[5*c +: 5] != 5'd0) begin
                    r_val[cm_rd[5*c +: 5]] <= cm_data[XLEN*c +: XLEN];
                    // A stale tag still writes the value but leaves busy alone.
                    if (cm_tag[TAG_W*c +: TAG_W] == r_tag[cm_rd[5*c +: 5]]) begin
                        r_busy[cm_rd[5*c +: 5]] <= 1'b0;
                    end
                end
            end

            if (flush) begin
                r_busy <= '0;
            end else begin
                for (int j = 0; j < DISP_W; j++) begin
                    if (ds_valid[j] && ds_rd[5*j +: 5] != 5'd0) begin
                        r_busy[ds_rd[5*j +: 5]] <= 1'b1;
                        r_tag[ds_rd[5*j +: 5]]  <= ds_tag[TAG_W*j +: TAG_W];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_regfile_mp
// Description : Self-checking bench for rename_regfile_mp. Each table record
//               is one clock cycle of stimulus plus the expected read results
//               for that cycle, compared before the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_regfile_mp;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [1:0]  cm_valid;
    logic [9:0]  cm_rd;
    logic [9:0]  cm_tag;
    logic [63:0] cm_data;
    logic [1:0]  ds_valid;
    logic [9:0]  ds_rd;
    logic [9:0]  ds_tag;
    logic [9:0]  ds_rs1;
    logic [9:0]  ds_rs2;
    logic [1:0]  rs1_rdy;
    logic [9:0]  rs1_tag;
    logic [63:0] rs1_val;
    logic [1:0]  rs2_rdy;
    logic [9:0]  rs2_tag;
    logic [63:0] rs2_val;

    rename_regfile_mp #(
        .XLEN(32), .TAG_W(5), .DISP_W(2), .COMMIT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
        .ds_valid(ds_valid), .ds_rd(ds_rd), .ds_tag(ds_tag),
        .ds_rs1(ds_rs1), .ds_rs2(ds_rs2),
        .rs1_rdy(rs1_rdy), .rs1_tag(rs1_tag), .rs1_val(rs1_val),
        .rs2_rdy(rs2_rdy), .rs2_tag(rs2_tag), .rs2_val(rs2_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read index k = 2*slot + source (source 0 = rs1, 1 = rs2).
    typedef struct packed {
        logic             rdy;
        logic             flush;
        logic [1:0]       cmv;
        logic [1:0][4:0]  cmrd;
        logic [1:0][4:0]  cmtag;
        logic [1:0][31:0] cmdat;
        logic [1:0]       dsv;
        logic [1:0][4:0]  dsrd;
        logic [1:0][4:0]  dstag;
        logic [1:0][4:0]  rs1;
        logic [1:0][4:0]  rs2;
        logic [3:0]       chk;
        logic [3:0]       erdy;
        logic [3:0][4:0]  etag;
        logic [3:0][31:0] eval;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_pass;

    function automatic vec_t idle();
        vec_t v;
        v     = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic vec_t cm(vec_t v, int c, int rd, int tag, int dat);
        v.cmv[c]   = 1'b1;
        v.cmrd[c]  = 5'(rd);
        v.cmtag[c] = 5'(tag);
        v.cmdat[c] = 32'(dat);
        return v;
    endfunction

    function automatic vec_t ds(vec_t v, int j, int rd, int tag);
        v.dsv[j]   = 1'b1;
        v.dsrd[j]  = 5'(rd);
        v.dstag[j] = 5'(tag);
        return v;
    endfunction

    function automatic vec_t rs(vec_t v, int j, int s1, int s2);
        v.rs1[j] = 5'(s1);
        v.rs2[j] = 5'(s2);
        return v;
    endfunction

    function automatic vec_t ex(vec_t v, int k, bit r, int tag, int val);
        v.chk[k]  = 1'b1;
        v.erdy[k] = r;
        v.etag[k] = 5'(tag);
        v.eval[k] = 32'(val);
        return v;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rdy      = v.rdy;
        flush    = v.flush;
        cm_valid = v.cmv;
        cm_rd    = v.cmrd;
        cm_tag   = v.cmtag;
        cm_data  = v.cmdat;
        ds_valid = v.dsv;
        ds_rd    = v.dsrd;
        ds_tag   = v.dstag;
        ds_rs1   = v.rs1;
        ds_rs2   = v.rs2;
    endtask

    task automatic read_port(int k, output logic r, output logic [4:0] t,
                             output logic [31:0] d);
        int j;
        j = k / 2;
        if (k % 2 == 0) begin
            r = rs1_rdy[j]; t = rs1_tag[5*j +: 5]; d = rs1_val[32*j +: 32];
        end else begin
            r = rs2_rdy[j]; t = rs2_tag[5*j +: 5]; d = rs2_val[32*j +: 32];
        end
    endtask

    task automatic check_vec(vec_t v, int idx);
        logic        r;
        logic [4:0]  t;
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            if (v.chk[k]) begin
                read_port(k, r, t, d);
                check($sformatf("rdy[k%0d]", k), idx, 32'(r), 32'(v.erdy[k]));
                check($sformatf("tag[k%0d]", k), idx, 32'(t), 32'(v.etag[k]));
                if (v.erdy[k]) check($sformatf("val[k%0d]", k), idx, d, v.eval[k]);
            end
        end
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_pass   = 0;

        // 1: first cycle after reset; dispatch x5 tag3, commit to x0
        v = idle(); v = ds(v, 0, 5, 3); v = cm(v, 0, 0, 0, 7);
        v = rs(v, 0, 5, 0); v = rs(v, 1, 0, 5);
        v = ex(v, 0, 1, 0, 0); v = ex(v, 1, 1, 0, 0);
        v = ex(v, 2, 1, 0, 0); v = ex(v, 3, 0, 3, 0);
        vecs.push_back(v);
        v = idle(); v = rs(v, 0, 0, 5);
        v = ex(v, 0, 1, 0, 0); v = ex(v, 1, 0, 3, 0);
        vecs.push_back(v);
        // 2: commit bypass of x5, then busy cleared
        v = idle(); v = cm(v, 0, 5, 3, 'h1234); v = rs(v, 0, 5, 0); v = rs(v, 1, 5, 0);
        v = ex(v, 0, 1, 0, 'h1234); v = ex(v, 2, 1, 0, 'h1234);
        vecs.push_back(v);
        v = idle(); v = rs(v, 0, 5, 0); v = ex(v, 0, 1, 0, 'h1234);
        vecs.push_back(v);
        // 3: intra-bundle rename of x7
        v = idle(); v = ds(v, 0, 7, 9); v = rs(v, 0, 7, 0); v = rs(v, 1, 7, 7);
        v = ex(v, 0, 1, 0, 0); v = ex(v, 2, 0, 9, 0); v = ex(v, 3, 0, 9, 0);
        vecs.push_back(v);
        // invalid slot 0 naming x7 must not rename it
        v = idle(); v.dsrd[0] = 5'd7; v.dstag[0] = 5'd1; v = rs(v, 1, 0, 7);
        v = ex(v, 3, 0, 9, 0);
        vecs.push_back(v);
        // stale commit to x7: no bypass, busy kept
        v = idle(); v = cm(v, 0, 7, 3, 'h77); v = rs(v, 0, 7, 0);
        v = ex(v, 0, 0, 9, 0);
        vecs.push_back(v);
        // 4: x8 renamed twice, stale commit, then commit + same-cycle rename
        v = idle(); v = ds(v, 0, 8, 4); vecs.push_back(v);
        v = idle(); v = ds(v, 0, 8, 6); v = rs(v, 0, 8, 0); v = ex(v, 0, 0, 4, 0);
        vecs.push_back(v);
        v = idle(); v = cm(v, 0, 8, 4, 5); v = rs(v, 0, 8, 0); v = ex(v, 0, 0, 6, 0);
        vecs.push_back(v);
        v = idle(); v = cm(v, 0, 8, 6, 1); v = ds(v, 0, 8, 2);
        v = rs(v, 0, 8, 0); v = rs(v, 1, 8, 0);
        v = ex(v, 0, 1, 0, 1); v = ex(v, 2, 0, 2, 0);
        vecs.push_back(v);
        v = idle(); v = rs(v, 0, 8, 0); v = ex(v, 0, 0, 2, 0); vecs.push_back(v);
        v = idle(); v = cm(v, 1, 8, 2, 'h55); vecs.push_back(v);
        v = idle(); v = rs(v, 0, 8, 0); v = ex(v, 0, 1, 0, 'h55); vecs.push_back(v);
        // 5: two ports commit x3 (not busy: tag match must not bypass)
        v = idle(); v = cm(v, 0, 3, 0, 1); v = cm(v, 1, 3, 0, 2); v = rs(v, 0, 3, 0);
        v = ex(v, 0, 1, 0, 0);
        vecs.push_back(v);
        v = idle(); v = ds(v, 0, 3, 1); v = ds(v, 1, 3, 2);
        v = rs(v, 0, 3, 0); v = rs(v, 1, 3, 0);
        v = ex(v, 0, 1, 0, 2); v = ex(v, 2, 0, 1, 0);
        vecs.push_back(v);
        v = idle(); v = rs(v, 0, 3, 0); v = ex(v, 0, 0, 2, 0); vecs.push_back(v);
        v = idle(); v = cm(v, 0, 3, 2, 'h10); v = cm(v, 1, 3, 2, 'h20); v = rs(v, 0, 3, 0);
        v = ex(v, 0, 1, 0, 'h20);
        vecs.push_back(v);
        v = idle(); v = rs(v, 0, 3, 0); v = ex(v, 0, 1, 0, 'h20); vecs.push_back(v);
        // 6: several busy registers, then flush
        v = idle(); v = ds(v, 0, 4, 11); v = ds(v, 1, 6, 12); vecs.push_back(v);
        v = idle(); v = ds(v, 0, 31, 31); vecs.push_back(v);
        v = idle(); v.flush = 1'b1; v = cm(v, 0, 4, 5, 9); v = ds(v, 0, 6, 13);
        v = rs(v, 0, 4, 0); v = rs(v, 1, 6, 31);
        v = ex(v, 0, 0, 11, 0); v = ex(v, 2, 0, 13, 0); v = ex(v, 3, 0, 31, 0);
        vecs.push_back(v);
        v = idle(); v = ds(v, 0, 10, 14); v = rs(v, 0, 4, 6); v = rs(v, 1, 7, 31);
        v = ex(v, 0, 1, 0, 9); v = ex(v, 1, 1, 0, 0);
        v = ex(v, 2, 1, 0, 'h77); v = ex(v, 3, 1, 0, 0);
        vecs.push_back(v);
        // rdy low for three cycles: no state change, reads still live
        v = idle(); v.rdy = 1'b0; v = cm(v, 0, 4, 0, 'hDEAD); v = ds(v, 0, 4, 1);
        v = rs(v, 0, 4, 0); v = rs(v, 1, 4, 0);
        v = ex(v, 0, 1, 0, 9); v = ex(v, 2, 0, 1, 0);
        vecs.push_back(v);
        v = idle(); v.rdy = 1'b0; v = cm(v, 1, 9, 0, 5); v = ds(v, 0, 9, 2);
        v = rs(v, 0, 4, 0); v = ex(v, 0, 1, 0, 9);
        vecs.push_back(v);
        v = idle(); v.rdy = 1'b0; v.flush = 1'b1; v = cm(v, 0, 4, 0, 1);
        v = rs(v, 0, 9, 10); v = ex(v, 0, 1, 0, 0); v = ex(v, 1, 0, 14, 0);
        vecs.push_back(v);
        v = idle(); v = rs(v, 0, 4, 9); v = rs(v, 1, 10, 0);
        v = ex(v, 0, 1, 0, 9); v = ex(v, 1, 1, 0, 0); v = ex(v, 2, 0, 14, 0);
        vecs.push_back(v);

        // Reset sequence
        drive(idle());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            check_vec(vecs[i], i);
            @(negedge clk);
        end

        // Mid-run reset clears values, busy bits and tags.
        drive(idle());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ds_rs1 = {5'd10, 5'd4};
        ds_rs2 = {5'd0, 5'd8};
        #2;
        check("reset x4 rdy", -1, 32'(rs1_rdy[0]), 32'd1);
        check("reset x4 val", -1, rs1_val[31:0], 32'd0);
        check("reset x8 val", -1, rs2_val[31:0], 32'd0);
        check("reset x10 rdy", -1, 32'(rs1_rdy[1]), 32'd1);
        check("reset x10 tag", -1, 32'(rs1_tag[9:5]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
